// File: rtl/ahb_bram_pkg.sv
// Shared types and constants for the AHB-Lite block-RAM front end.
package ahb_bram_pkg;

   localparam int LANE_W = 4;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD,
      ST_RD_STALL,
      ST_ERR1,
      ST_ERR2
   } state_e;

endpackage

// File: rtl/ahb_bram_if.sv
// AHB-Lite bus bundle between a master and the block-RAM slave.
interface ahb_bram_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic        HREADY;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb_bram_lane_dec.sv
// HSIZE + low address bits to byte-lane mask. With AHB_BRAM_ERR_EN undefined
// misaligned transfers are forced aligned and oversize is treated as a word.
module ahb_bram_lane_dec
   import ahb_bram_pkg::*;
(
   input  logic [2:0]        hsize_i,
   input  logic [1:0]        addr_lo_i,
   output logic [LANE_W-1:0] mask_o,
   output logic              err_o
);

   always_comb begin
      mask_o = '0;
      err_o  = 1'b0;
      case (hsize_i)
         HSIZE_BYTE: mask_o = LANE_W'(1) << addr_lo_i;
         HSIZE_HALF: begin
            mask_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
`ifdef AHB_BRAM_ERR_EN
            err_o  = addr_lo_i[0];
`endif
         end
         HSIZE_WORD: begin
            mask_o = 4'b1111;
`ifdef AHB_BRAM_ERR_EN
            err_o  = |addr_lo_i;
`endif
         end
         default: begin
`ifdef AHB_BRAM_ERR_EN
            err_o  = 1'b1;
`else
            mask_o = 4'b1111;
`endif
         end
      endcase
   end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave driving a single-port byte-lane RAM. ERROR responses for
// misaligned/oversize transfers exist only when AHB_BRAM_ERR_EN is defined.
module ahb_bram_ctrl
   import ahb_bram_pkg::*;
#(
   parameter int AW = 12
) (
   input  logic              clk,
   input  logic              rst,
   ahb_bram_if.slave         ahb,
   output logic [LANE_W-1:0] ram_we,
   output logic              ram_cs,
   output logic [AW-1:0]     ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout
);

   state_e              state_q;
   logic [LANE_W-1:0]   we_q;
   logic [AW-1:0]       waddr_q;
   logic [AW-1:0]       raddr_q;
   logic                hready_q;
   logic                hresp_q;

   logic [LANE_W-1:0]   mask;
   logic                dec_err;
   logic                accept, acc_err, acc_wr, acc_rd;
   logic [AW-1:0]       haddr_w;
   logic                unused_ok;

   ahb_bram_lane_dec u_lane_dec (
      .hsize_i   (ahb.HSIZE),
      .addr_lo_i (ahb.HADDR[1:0]),
      .mask_o    (mask),
      .err_o     (dec_err)
   );

   assign haddr_w   = ahb.HADDR[AW+1:2];
   assign unused_ok = ^{ahb.HADDR[31:AW+2], ahb.HTRANS[0]};

   // Only phases presented while we are ready count; reset wins over any phase.
   assign accept  = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & hready_q & ~rst;
   assign acc_err = accept & dec_err;
   assign acc_wr  = accept & ~dec_err & ahb.HWRITE;
   assign acc_rd  = accept & ~dec_err & ~ahb.HWRITE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         we_q     <= '0;
         waddr_q  <= '0;
         raddr_q  <= '0;
         hready_q <= 1'b1;
         hresp_q  <= 1'b0;
      end else begin
         hready_q <= 1'b1;
         hresp_q  <= 1'b0;
         case (state_q)
            ST_RD_STALL: state_q <= ST_RD;
`ifdef AHB_BRAM_ERR_EN
            ST_ERR1: begin
               state_q <= ST_ERR2;
               hresp_q <= 1'b1;
            end
`endif
            default: begin
`ifdef AHB_BRAM_ERR_EN
               if (acc_err) begin
                  state_q  <= ST_ERR1;
                  hready_q <= 1'b0;
                  hresp_q  <= 1'b1;
               end else
`endif
               if (acc_wr) begin
                  state_q <= ST_WR;
                  waddr_q <= haddr_w;
                  we_q    <= mask;
               end else if (acc_rd) begin
                  // RAM port is busy with the pending write: stall one cycle.
                  if (state_q == ST_WR) begin
                     state_q  <= ST_RD_STALL;
                     raddr_q  <= haddr_w;
                     hready_q <= 1'b0;
                  end else begin
                     state_q <= ST_RD;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

   always_comb begin
      ram_we   = (state_q == ST_WR && !rst) ? we_q : '0;
      ram_cs   = 1'b0;
      ram_addr = '0;
      if (state_q == ST_WR)
         ram_addr = waddr_q;
      if (state_q == ST_RD_STALL && !rst) begin
         ram_cs   = 1'b1;
         ram_addr = raddr_q;
      end else if (acc_rd && state_q != ST_WR) begin
         ram_cs   = 1'b1;
         ram_addr = haddr_w;
      end
   end

   assign ram_din       = ahb.HWDATA;
   assign ahb.HRDATA    = (state_q == ST_RD) ? ram_dout : 32'h0;
   assign ahb.HREADYOUT = hready_q;
   // hresp_q is never set unless the error path is compiled in.
   assign ahb.HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed bench for ahb_bram_ctrl with a behavioural RAM and a read scoreboard.
module tb_ahb_bram_ctrl;
   localparam int AW = 12;
`ifdef AHB_BRAM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  ram_we;
   logic        ram_cs;
   logic [AW-1:0] ram_addr;
   logic [31:0] ram_din, ram_dout, rd_q;
   logic [31:0] mem     [0:(1<<AW)-1];
   logic [31:0] ref_mem [0:(1<<AW)-1];
   exp_t        sb[$];
   exp_t        mon_e;
   logic        rd_pend;
   int          n_assert = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   ahb_bram_if bus ();
   assign bus.HREADY = bus.HREADYOUT;

   ahb_bram_ctrl #(.AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .ahb      (bus.slave),
      .ram_we   (ram_we),
      .ram_cs   (ram_cs),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   // Single-port RAM: registered address, zero output when not selected.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
      rd_q <= ram_cs ? mem[ram_addr] : 32'h0;
   end
   assign ram_dout = rd_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   function automatic void ref_wr(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
      int nb   = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
      int base = (sz == 3'd0) ? int'(a[1:0]) : (sz == 3'd1) ? 2 * int'(a[1]) : 0;
      for (int b = base; b < base + nb; b++)
         ref_mem[a[AW+1:2]][8*b +: 8] = d[8*b +: 8];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.HSEL   = 1'b0;
      bus.HTRANS = 2'd0;
      bus.HWRITE = 1'b0;
   endtask

   task automatic addr(input logic wr, input logic [2:0] sz, input logic [31:0] a);
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'd2;
      bus.HWRITE = wr;
      bus.HSIZE  = sz;
      bus.HADDR  = a;
   endtask

   task automatic rd_addr(input logic [2:0] sz, input logic [31:0] a, input logic err);
      exp_t e;
      addr(1'b0, sz, a);
      e.err  = err;
      e.data = err ? 32'h0 : ref_mem[a[AW+1:2]];
      sb.push_back(e);
   endtask

   // Read data phase completes when HREADYOUT is high after an accepted read.
   always @(posedge clk) begin
      if (rst) rd_pend <= 1'b0;
      else if (bus.HREADYOUT) rd_pend <= bus.HSEL & bus.HTRANS[1] & ~bus.HWRITE;
   end

   always @(negedge clk) begin
      if (!rst && rd_pend && bus.HREADYOUT) begin
         if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL sb_underflow: observed unexpected read completion, required none");
         end else begin
            mon_e = sb.pop_front();
            chk("rd_data", bus.HRDATA, mon_e.data);
            chk("rd_resp", 32'(bus.HRESP), 32'(mon_e.err));
         end
      end
   end

   initial begin
      bus_idle();
      bus.HSIZE  = 3'd0;
      bus.HADDR  = 32'h0;
      bus.HWDATA = 32'h0;

      // Reset state
      @(negedge clk);
      chk("rst_hready", 32'(bus.HREADYOUT), 32'd1);
      chk("rst_hresp",  32'(bus.HRESP),     32'd0);
      chk("rst_we",     32'(ram_we),        32'd0);
      chk("rst_cs",     32'(ram_cs),        32'd0);
      chk("rst_hrdata", bus.HRDATA,         32'h0);
      tick();
      rst = 1'b0;

      // Preload words 0,1,2,8 with back-to-back writes
      addr(1'b1, 3'd2, 32'h0); tick();
      bus.HWDATA = 32'h0123_4567; ref_wr(3'd2, 32'h0, bus.HWDATA);
      addr(1'b1, 3'd2, 32'h4);
      @(negedge clk);
      chk("pre_we0",   32'(ram_we),   32'hF);
      chk("pre_addr0", 32'(ram_addr), 32'd0);
      tick();
      bus.HWDATA = 32'h89AB_CDEF; ref_wr(3'd2, 32'h4, bus.HWDATA);
      addr(1'b1, 3'd2, 32'h8);
      @(negedge clk);
      chk("pre_rdy1",  32'(bus.HREADYOUT), 32'd1);
      chk("pre_addr1", 32'(ram_addr),      32'd1);
      tick();
      bus.HWDATA = 32'h5A5A_A5A5; ref_wr(3'd2, 32'h8, bus.HWDATA);
      addr(1'b1, 3'd2, 32'h20); tick();
      bus.HWDATA = 32'h7777_0001; ref_wr(3'd2, 32'h20, bus.HWDATA);
      bus_idle(); tick();

      // Word write 0x10 then read back with one wait state
      addr(1'b1, 3'd2, 32'h10); tick();
      bus.HWDATA = 32'hDEAD_BEEF; ref_wr(3'd2, 32'h10, bus.HWDATA);
      rd_addr(3'd2, 32'h10, 1'b0);
      @(negedge clk);
      chk("t1_we",   32'(ram_we),   32'hF);
      chk("t1_addr", 32'(ram_addr), 32'd4);
      chk("t1_din",  ram_din,       32'hDEAD_BEEF);
      tick();
      bus_idle();
      @(negedge clk);
      chk("t1_stall", 32'(bus.HREADYOUT), 32'd0);
      tick(); tick();

      // Byte write lane 2 then read back
      addr(1'b1, 3'd0, 32'h12); tick();
      bus.HWDATA = 32'h00AA_0000; ref_wr(3'd0, 32'h12, bus.HWDATA);
      rd_addr(3'd2, 32'h10, 1'b0);
      @(negedge clk);
      chk("t2_we",   32'(ram_we),   32'h4);
      chk("t2_addr", 32'(ram_addr), 32'd4);
      chk("t2_ref",  ref_mem[4],    32'hDEAA_BEEF);
      tick(); bus_idle(); tick(); tick();

      // Back-to-back reads
      rd_addr(3'd2, 32'h0, 1'b0); tick();
      rd_addr(3'd2, 32'h4, 1'b0);
      @(negedge clk); chk("t3_rdy_a", 32'(bus.HREADYOUT), 32'd1);
      tick();
      rd_addr(3'd2, 32'h8, 1'b0);
      @(negedge clk); chk("t3_rdy_b", 32'(bus.HREADYOUT), 32'd1);
      tick();
      bus_idle();
      @(negedge clk); chk("t3_rdy_c", 32'(bus.HREADYOUT), 32'd1);
      tick();

      // Misaligned word read
      rd_addr(3'd2, 32'h2, ERR_EN);
      @(negedge clk); chk("t4_cs_addr", 32'(ram_cs), ERR_EN ? 32'd0 : 32'd1);
      tick();
      bus_idle();
      @(negedge clk);
      chk("t4_rdy1",  32'(bus.HREADYOUT), ERR_EN ? 32'd0 : 32'd1);
      chk("t4_resp1", 32'(bus.HRESP),     ERR_EN ? 32'd1 : 32'd0);
      chk("t4_we1",   32'(ram_we),        32'd0);
      tick();
      @(negedge clk);
      chk("t4_rdy2",  32'(bus.HREADYOUT), 32'd1);
      chk("t4_resp2", 32'(bus.HRESP),     ERR_EN ? 32'd1 : 32'd0);
      chk("t4_cs2",   32'(ram_cs),        32'd0);
      tick();

      // Halfword write followed by IDLE, then read back
      addr(1'b1, 3'd1, 32'h6); tick();
      bus.HWDATA = 32'h1234_0000; ref_wr(3'd1, 32'h6, bus.HWDATA);
      bus_idle();
      @(negedge clk);
      chk("t5_we",   32'(ram_we),   32'hC);
      chk("t5_addr", 32'(ram_addr), 32'd1);
      tick();
      @(negedge clk);
      chk("t5_we_idle",  32'(ram_we),          32'd0);
      chk("t5_rdy_idle", 32'(bus.HREADYOUT),   32'd1);
      tick();
      rd_addr(3'd2, 32'h4, 1'b0); tick();
      bus_idle(); tick();

      // Reset during a write data phase: word 8 must keep its old value
      addr(1'b1, 3'd2, 32'h20); tick();
      bus.HWDATA = 32'hCAFE_F00D;
      bus_idle();
      rst = 1'b1;
      @(negedge clk);
      chk("t6_we_rst", 32'(ram_we), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rdy",  32'(bus.HREADYOUT), 32'd1);
      chk("t6_resp", 32'(bus.HRESP),     32'd0);
      tick();
      rd_addr(3'd2, 32'h20, 1'b0); tick();
      bus_idle(); tick(); tick();

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_bram_ctrl.md
# ahb_bram_ctrl

AHB-Lite slave front end for the byte-lane block RAM in the AHB_BRAM subsystem. It decodes AHB address/data phases into the RAM's per-lane write enables, chip select, word address and write data, and returns RAM read data as HRDATA. Reads complete with zero wait states. A read that follows a write gets one wait state, because the RAM has a single port. Misaligned or oversize transfers receive a two-cycle ERROR response.

## Interface
Parameters:
- AW, 12, RAM word-address width; RAM holds 2^AW 32-bit words; byte address bits used are HADDR[AW+1:0]

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ (active)
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word
- HREADY  in  1  bus ready (address phase sampled only when high)
- HWDATA  in  32  write data, valid in data phase
- HRDATA  out  32  read data
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- ram_we  out  4  per-byte-lane write enable
- ram_cs  out  1  RAM chip select (read issue)
- ram_addr  out  AW  RAM word address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data; registered address, valid the cycle after issue, zero if ram_cs was low at issue

## Operation
- Accepted address phase: HSEL & HREADY & HTRANS[1].
- Lane decode:
  - byte → mask = 1 << HADDR[1:0]
  - halfword → 0011 if HADDR[1] = 0, else 1100
  - word → 1111
  - error if halfword with HADDR[0] = 1, word with HADDR[1:0] ≠ 0, or HSIZE > 2
- States and their outputs:
  - IDLE: HREADYOUT = 1, HRESP = 0
  - WR: write data phase; ram_we = registered mask, ram_addr = registered word address, ram_din = HWDATA, ram_cs = 0
  - RD: read data phase; HRDATA = ram_dout
  - RD_STALL: ram_cs = 1, ram_addr = captured read address, HREADYOUT = 0
  - ERR1: HREADYOUT = 0, HRESP = 1
  - ERR2: HREADYOUT = 1, HRESP = 1
- Transitions, evaluated on each accepted phase, from any state with HREADYOUT = 1:
  - accepted error transfer → ERR1; no RAM access
  - accepted write → WR; register word address and mask
  - accepted read while in WR → RD_STALL; capture HADDR[AW+1:2]
  - accepted read in any other state → RD; ram_cs = 1 and ram_addr = HADDR[AW+1:2] driven combinationally in that same cycle
  - no accepted transfer → IDLE
- Fixed transitions:
  - RD_STALL → RD unconditionally
  - ERR1 → ERR2 unconditionally
- Default outputs: HRDATA = 0 outside RD; ram_we = 0 outside WR.
- Reset: state IDLE, HREADYOUT = 1, HRESP = 0, ram_we = 0, ram_cs = 0, HRDATA = 0, all captured registers 0. Reset mid-transfer abandons it with no RAM write.

## Timing
- Read: address phase in cycle N; HRDATA valid with HREADYOUT = 1 in N+1. Back-to-back reads sustain one per cycle.
- Write: address phase in N; RAM written at the end of N+1. Back-to-back writes sustain one per cycle.
- Read following a write: data in N+2, with HREADYOUT = 0 in N+1. A read of the address just written returns the new data.
- Write following a read: no wait.
- ERROR: two cycles. Any address phase presented during ERR1 is ignored, since HREADY is low.
- No combinational path from HWDATA to HREADYOUT or HRESP.

## Configuration
- AHB_BRAM_ERR_EN defined: the lane-decode error check and the ERR1/ERR2 states are compiled in, as described above.
- AHB_BRAM_ERR_EN undefined: no ERROR responses; HRESP is tied to 0.
  - Misaligned halfword/word transfers are forced to alignment (low address bits ignored).
  - HSIZE > 2 is treated as a word transfer.

## Structure
- Package ahb_bram_pkg holds:
  - HTRANS codes (IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3)
  - HSIZE codes
  - the state enum (IDLE, WR, RD, RD_STALL, ERR1, ERR2)
  - the lane-mask width constant
- Sub-module ahb_bram_lane_dec: combinational HSIZE + HADDR[1:0] → 4-bit mask plus error flag. Its error output is forced to 0 when AHB_BRAM_ERR_EN is undefined.

## Test plan
- Word write 0xDEADBEEF to 0x10, then word read 0x10 → ram_we = 1111 at word address 4; HRDATA = 0xDEADBEEF after one wait cycle.
- Byte write 0xAA on lane 2 to 0x12, then word read 0x10 → ram_we = 0100; HRDATA = 0xDEAABEEF.
- Back-to-back reads of 0x0, 0x4, 0x8 → HREADYOUT stays 1; HRDATA returns the three preloaded words on consecutive cycles.
- Word read at 0x2 with AHB_BRAM_ERR_EN defined → one cycle HREADYOUT = 0 / HRESP = 1, then one cycle HREADYOUT = 1 / HRESP = 1; ram_cs and ram_we stay 0. Same stimulus with the macro undefined → OKAY response returning word 0.
- Halfword write 0x1234 to 0x6 followed by HTRANS = IDLE → ram_we = 1100 at word address 1; the state returns to IDLE.
- Assert rst in the data phase of a write → ram_we = 0 that cycle, RAM contents unchanged, HREADYOUT = 1 and HRESP = 0 after reset.
